// File: rtl/sonar_tof_detector.sv
// sonar_tof_detector: multi-channel echo detector with time-of-flight capture.
// Runs a blank/listen/done ping sequence paced by the PCM strobe or by manual
// ticks. It requires HOLD consecutive above-threshold samples per channel
// before it declares an echo. All control and results go through a 16-bit
// register slave.
module sonar_tof_detector #(
  parameter int NCH    = 4,
  parameter int DW     = 16,
  parameter int TW     = 16,
  parameter int ADDR_W = 5
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                wb_valid_i,
  input  logic [ADDR_W-1:0]   wbs_adr_i,
  input  logic [15:0]         wbs_dat_i,
  input  logic                wbs_strb_i,
  output logic                wbs_ack_o,
  output logic [15:0]         wbs_dat_o,
  input  logic [NCH*DW-1:0]   mag_i,
  input  logic                ce_pcm,
  input  logic                mclear,
  output logic [NCH-1:0]      cmp,
  output logic                irq,
  output logic                busy
);

  // Run counters span the full 16-bit HOLD range. Timer comparisons use one
  // extra bit so that timer+1 cannot wrap.
  localparam int RW = 16;
  localparam int CW = ((TW > 16) ? TW : 16) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BLANK  = 2'd1,
    S_LISTEN = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic             r_pace;
  logic             r_irq_en;
  logic             r_cont;
  logic [7:0]       r_mask;
  logic [15:0]      r_blank;
  logic [15:0]      r_timeout;
  logic [15:0]      r_hold;
  logic [DW-1:0]    r_thresh [NCH];

  logic [TW-1:0]    r_timer;
  logic [NCH-1:0]   r_det;
  logic             r_done;
  logic [RW-1:0]    r_run [NCH];
  logic [TW-1:0]    r_tof [NCH];
  logic             r_irq;

  logic             w_wr;
  logic             w_wr_ctrl;
  logic             w_start;
  logic             w_tick;
  logic             w_enter_done;
  logic             w_w1c_done;
  logic [NCH-1:0]   w_en;
  logic [NCH-1:0]   w_above;
  logic [NCH-1:0]   w_hit;
  logic [RW-1:0]    w_run_inc [NCH];
  logic [15:0]      w_hold_eff;
  logic [TW-1:0]    w_timer_sat;
  logic [CW-1:0]    w_timer_p1;
  logic             w_blank_done;
  logic             w_listen_done;
  logic [15:0]      w_rdata;

  assign w_wr       = wb_valid_i & wbs_strb_i;
  assign w_wr_ctrl  = w_wr & (int'(wbs_adr_i) == 0);
  assign w_w1c_done = w_wr & (int'(wbs_adr_i) == 1) & wbs_dat_i[0];
  assign w_tick     = r_pace ? (w_wr_ctrl & wbs_dat_i[2]) : ce_pcm;
  assign w_start    = ~mclear &
                      ((w_wr_ctrl & wbs_dat_i[0] & ((r_state == S_IDLE) | (r_state == S_DONE))) |
                       ((r_state == S_DONE) & r_cont));
  assign w_en        = r_mask[NCH-1:0];
  assign w_hold_eff  = (r_hold == 16'd0) ? 16'd1 : r_hold;
  assign w_timer_sat = (&r_timer) ? r_timer : r_timer + TW'(1);
  assign w_timer_p1  = CW'(r_timer) + CW'(1);
  assign w_blank_done = (w_timer_p1 >= CW'(r_blank));
  assign w_listen_done = (&(r_det | w_hit | ~w_en)) |
                         ((r_timeout != 16'd0) & (w_timer_p1 == CW'(r_timeout)));
  assign w_enter_done = (w_state_next == S_DONE) & (r_state != S_DONE);

  assign cmp = r_det;
  assign irq = r_irq;

  // Per-channel threshold compare and detection of a completed hold run
  always_comb begin
    w_above = '0;
    w_hit   = '0;
    for (int c = 0; c < NCH; c++) begin
      w_run_inc[c] = (&r_run[c]) ? r_run[c] : r_run[c] + RW'(1);
      w_above[c]   = mag_i[c*DW +: DW] > r_thresh[c];
      w_hit[c]     = w_en[c] & ~r_det[c] & w_above[c] & (w_run_inc[c] >= w_hold_eff);
    end
  end

  // State register for the ping sequencer
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Ping sequencer transitions; master clear overrides everything
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state == S_BLANK) | (r_state == S_LISTEN);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_start) w_state_next = (r_blank != 16'd0) ? S_BLANK : S_LISTEN;
      end
      S_BLANK: begin
        if (w_tick && w_blank_done) w_state_next = S_LISTEN;
      end
      S_LISTEN: begin
        if (w_tick && w_listen_done) w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
    if (mclear) w_state_next = S_IDLE;
  end

  // Configuration registers written from the bus
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_pace    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_cont    <= 1'b0;
      r_mask    <= 8'h00;
      r_blank   <= 16'd0;
      r_timeout <= 16'd0;
      r_hold    <= 16'd1;
      for (int c = 0; c < NCH; c++) r_thresh[c] <= DW'(16'h0010);
    end else if (w_wr) begin
      case (int'(wbs_adr_i))
        0: begin
          r_pace   <= wbs_dat_i[1];
          r_irq_en <= wbs_dat_i[3];
          r_cont   <= wbs_dat_i[4];
          r_mask   <= wbs_dat_i[15:8];
        end
        2: r_blank   <= wbs_dat_i;
        3: r_timeout <= wbs_dat_i;
        4: r_hold    <= wbs_dat_i;
        default: ;
      endcase
      for (int c = 0; c < NCH; c++) begin
        if (int'(wbs_adr_i) == 16 + c) r_thresh[c] <= DW'(wbs_dat_i);
      end
    end
  end

  // Ping datapath: timer, run counters, detect flags, TOF capture, done flag
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_timer <= '0;
      r_det   <= '0;
      r_done  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_run[c] <= '0;
        r_tof[c] <= '1;
      end
    end else if (mclear) begin
      r_timer <= '0;
      r_det   <= '0;
      r_done  <= 1'b0;
      for (int c = 0; c < NCH; c++) r_run[c] <= '0;
    end else if (w_start) begin
      r_timer <= '0;
      r_det   <= '0;
      r_done  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        r_run[c] <= '0;
        r_tof[c] <= '1;
      end
    end else begin
      if (w_tick && r_state == S_BLANK) r_timer <= w_timer_sat;
      if (w_tick && r_state == S_LISTEN) begin
        for (int c = 0; c < NCH; c++) begin
          if (w_en[c] && !r_det[c]) begin
            if (w_above[c]) begin
              r_run[c] <= w_run_inc[c];
              if (w_hit[c]) begin
                r_det[c] <= 1'b1;
                r_tof[c] <= r_timer;
              end
            end else begin
              r_run[c] <= '0;
            end
          end
        end
        r_timer <= w_timer_sat;
      end
      if (w_enter_done)    r_done <= 1'b1;
      else if (w_w1c_done) r_done <= 1'b0;
    end
  end

  // Read mux over the register map; unmapped addresses read as zero
  always_comb begin
    w_rdata = 16'h0000;
    case (int'(wbs_adr_i))
      0: w_rdata = {r_mask, 3'b000, r_cont, r_irq_en, 1'b0, r_pace, 1'b0};
      1: w_rdata = {8'(r_det), 5'b00000, r_state, r_done};
      2: w_rdata = r_blank;
      3: w_rdata = r_timeout;
      4: w_rdata = r_hold;
      5: w_rdata = 16'(r_timer);
      default: ;
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (int'(wbs_adr_i) == 16 + c) w_rdata = 16'(r_thresh[c]);
      if (int'(wbs_adr_i) == 24 + c) w_rdata = 16'(r_tof[c]);
    end
  end

  // Bus response: capture pre-write read data, one-cycle ack, registered irq
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= 16'h0000;
      r_irq     <= 1'b0;
    end else begin
      wbs_ack_o <= wb_valid_i;
      if (wb_valid_i) wbs_dat_o <= w_rdata;
      r_irq <= r_irq_en & r_done;
    end
  end

endmodule

// File: tb/tb_sonar_tof_detector.sv
// tb_sonar_tof_detector: directed, table-driven bench for sonar_tof_detector.
module tb_sonar_tof_detector;

  localparam int NCH    = 4;
  localparam int DW     = 16;
  localparam int TW     = 16;
  localparam int ADDR_W = 5;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_i;
  logic                wb_valid_i;
  logic [ADDR_W-1:0]   wbs_adr_i;
  logic [15:0]         wbs_dat_i;
  logic                wbs_strb_i;
  logic                wbs_ack_o;
  logic [15:0]         wbs_dat_o;
  logic [NCH*DW-1:0]   mag_i;
  logic                ce_pcm;
  logic                mclear;
  logic [NCH-1:0]      cmp;
  logic                irq;
  logic                busy;

  int nVec = 0;
  int nMis = 0;

  typedef struct {
    logic [4:0]  adr;
    logic [15:0] expData;
    string       name;
  } vec_t;

  vec_t resetTable[10];

  sonar_tof_detector #(.NCH(NCH), .DW(DW), .TW(TW), .ADDR_W(ADDR_W)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .wb_valid_i (wb_valid_i),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_strb_i (wbs_strb_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .mag_i      (mag_i),
    .ce_pcm     (ce_pcm),
    .mclear     (mclear),
    .cmp        (cmp),
    .irq        (irq),
    .busy       (busy)
  );

  // 100 MHz clock
  always #5 wb_clk_i = ~wb_clk_i;

  // Watchdog so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nVec++;
    if (actual !== expected) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One bus access; returns the read data and ack sampled one and two edges later
  task automatic applyStimulus(input logic [4:0] adr, input logic wr, input logic [15:0] dat,
                               output logic [15:0] rdata, output logic ackNow, output logic ackAfter);
    @(negedge wb_clk_i);
    wb_valid_i = 1'b1;
    wbs_adr_i  = adr;
    wbs_strb_i = wr;
    wbs_dat_i  = dat;
    @(posedge wb_clk_i);
    #1;
    rdata      = wbs_dat_o;
    ackNow     = wbs_ack_o;
    wb_valid_i = 1'b0;
    wbs_strb_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    ackAfter = wbs_ack_o;
  endtask

  task automatic regWrite(input logic [4:0] adr, input logic [15:0] dat);
    logic [15:0] d;
    logic a0, a1;
    applyStimulus(adr, 1'b1, dat, d, a0, a1);
  endtask

  task automatic checkReg(input string name, input logic [4:0] adr, input logic [15:0] expData);
    logic [15:0] d;
    logic a0, a1;
    applyStimulus(adr, 1'b0, 16'h0000, d, a0, a1);
    checkOutput(name, 32'(d), 32'(expData));
  endtask

  task automatic pcmTick();
    @(negedge wb_clk_i);
    ce_pcm = 1'b1;
    @(negedge wb_clk_i);
    ce_pcm = 1'b0;
  endtask

  task automatic setMag(input int c, input logic [DW-1:0] v);
    mag_i[c*DW +: DW] = v;
  endtask

  initial begin
    logic [15:0] rd;
    logic        ackNow, ackAfter;
    logic [15:0] pattern [6];

    resetTable[0] = '{5'd0,  16'h0000, "rst CONTROL"};
    resetTable[1] = '{5'd1,  16'h0000, "rst STATUS"};
    resetTable[2] = '{5'd2,  16'h0000, "rst BLANK"};
    resetTable[3] = '{5'd3,  16'h0000, "rst TIMEOUT"};
    resetTable[4] = '{5'd4,  16'h0001, "rst HOLD"};
    resetTable[5] = '{5'd5,  16'h0000, "rst TIMER"};
    resetTable[6] = '{5'd16, 16'h0010, "rst THRESH0"};
    resetTable[7] = '{5'd24, 16'hFFFF, "rst TOF0"};
    resetTable[8] = '{5'd27, 16'hFFFF, "rst TOF3"};
    resetTable[9] = '{5'd31, 16'h0000, "rst unmapped"};

    wb_rst_i   = 1'b1;
    wb_valid_i = 1'b0;
    wbs_adr_i  = '0;
    wbs_dat_i  = '0;
    wbs_strb_i = 1'b0;
    mag_i      = '0;
    ce_pcm     = 1'b0;
    mclear     = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    checkOutput("rst cmp",  32'(cmp), 32'h0);
    checkOutput("rst irq",  32'(irq), 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    checkOutput("rst ack",  32'(wbs_ack_o), 32'h0);
    checkOutput("rst dat",  32'(wbs_dat_o), 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // Reset register values and ack timing from the table
    for (int i = 0; i < 10; i++) begin
      applyStimulus(resetTable[i].adr, 1'b0, 16'h0000, rd, ackNow, ackAfter);
      checkOutput(resetTable[i].name, 32'(rd), 32'(resetTable[i].expData));
      if (i < 2) begin
        checkOutput("ack pulse", 32'(ackNow), 32'h1);
        checkOutput("ack drop",  32'(ackAfter), 32'h0);
      end
    end

    // Blanking, hold of 2, interrupt and W1C
    $display("[TB] blank/hold/irq sequence");
    regWrite(5'd2, 16'd3);
    regWrite(5'd4, 16'd2);
    regWrite(5'd16, 16'd100);
    setMag(0, 16'd200);
    regWrite(5'd0, 16'h0108);
    regWrite(5'd0, 16'h0109);
    checkOutput("busy after start", 32'(busy), 32'h1);
    pcmTick();
    pcmTick();
    checkReg("status in BLANK", 5'd1, 16'h0002);
    pcmTick();
    checkReg("status to LISTEN", 5'd1, 16'h0004);
    pcmTick();
    checkOutput("cmp before hold", 32'(cmp), 32'h0);
    pcmTick();
    checkOutput("cmp after hold", 32'(cmp), 32'h1);
    checkReg("TOF0 blank", 5'd24, 16'd4);
    checkReg("status DONE", 5'd1, 16'h0107);
    checkOutput("irq set", 32'(irq), 32'h1);
    checkOutput("busy in DONE", 32'(busy), 32'h0);
    regWrite(5'd1, 16'h0001);
    checkOutput("irq cleared", 32'(irq), 32'h0);
    checkReg("status after W1C", 5'd1, 16'h0106);

    // Timeout with one channel exactly at threshold
    $display("[TB] timeout / strict compare sequence");
    regWrite(5'd2, 16'd0);
    regWrite(5'd3, 16'd10);
    regWrite(5'd17, 16'd100);
    setMag(1, 16'd100);
    regWrite(5'd0, 16'h0308);
    regWrite(5'd0, 16'h0309);
    repeat (9) pcmTick();
    checkReg("status before timeout", 5'd1, 16'h0104);
    pcmTick();
    checkReg("status timeout", 5'd1, 16'h0107);
    checkReg("TOF1 none", 5'd25, 16'hFFFF);
    checkReg("TOF0 timeout run", 5'd24, 16'd1);
    checkReg("TIMER timeout", 5'd5, 16'd10);
    checkOutput("cmp timeout", 32'(cmp), 32'h1);

    // Broken run with hold of 3
    $display("[TB] run reset sequence");
    pattern[0] = 16'd200;
    pattern[1] = 16'd200;
    pattern[2] = 16'd50;
    pattern[3] = 16'd200;
    pattern[4] = 16'd200;
    pattern[5] = 16'd200;
    regWrite(5'd4, 16'd3);
    regWrite(5'd3, 16'd0);
    regWrite(5'd0, 16'h0109);
    for (int i = 0; i < 6; i++) begin
      setMag(0, pattern[i]);
      pcmTick();
      if (i == 4) checkOutput("cmp before 6th", 32'(cmp), 32'h0);
    end
    checkOutput("cmp at 6th", 32'(cmp), 32'h1);
    checkReg("TOF0 broken run", 5'd24, 16'd5);
    checkReg("status broken run", 5'd1, 16'h0107);

    // Master clear colliding with a start write during LISTEN
    $display("[TB] mclear sequence");
    regWrite(5'd4, 16'd1);
    setMag(0, 16'd200);
    setMag(1, 16'd0);
    regWrite(5'd0, 16'h0309);
    pcmTick();
    pcmTick();
    checkReg("TIMER before mclear", 5'd5, 16'd2);
    checkReg("status before mclear", 5'd1, 16'h0104);
    @(negedge wb_clk_i);
    mclear     = 1'b1;
    wb_valid_i = 1'b1;
    wbs_adr_i  = 5'd0;
    wbs_strb_i = 1'b1;
    wbs_dat_i  = 16'h0309;
    @(posedge wb_clk_i);
    #1;
    mclear     = 1'b0;
    wb_valid_i = 1'b0;
    wbs_strb_i = 1'b0;
    checkOutput("cmp after mclear", 32'(cmp), 32'h0);
    checkOutput("busy after mclear", 32'(busy), 32'h0);
    checkReg("status after mclear", 5'd1, 16'h0000);
    checkReg("TIMER after mclear", 5'd5, 16'd0);

    // Manual pacing ignores ce_pcm and counts control writes
    $display("[TB] manual pace sequence");
    setMag(0, 16'd0);
    regWrite(5'd0, 16'h0102);
    regWrite(5'd0, 16'h0103);
    for (int i = 0; i < 6; i++) begin
      @(negedge wb_clk_i);
      ce_pcm = ~ce_pcm;
    end
    ce_pcm = 1'b0;
    checkReg("TIMER frozen", 5'd5, 16'd0);
    repeat (3) regWrite(5'd0, 16'h0106);
    checkReg("TIMER manual", 5'd5, 16'd3);
    checkReg("status manual", 5'd1, 16'h0004);

    // Continuous mode re-enters BLANK one cycle after DONE
    $display("[TB] continuous sequence");
    @(negedge wb_clk_i);
    mclear = 1'b1;
    @(negedge wb_clk_i);
    mclear = 1'b0;
    regWrite(5'd2, 16'd2);
    setMag(0, 16'd200);
    regWrite(5'd0, 16'h0110);
    regWrite(5'd0, 16'h0111);
    pcmTick();
    pcmTick();
    pcmTick();
    checkOutput("cont DONE busy", 32'(busy), 32'h0);
    checkOutput("cont DONE cmp", 32'(cmp), 32'h1);
    @(posedge wb_clk_i);
    #1;
    checkOutput("cont restart busy", 32'(busy), 32'h1);
    checkOutput("cont restart cmp", 32'(cmp), 32'h0);
    checkReg("cont status BLANK", 5'd1, 16'h0002);

    // Asynchronous reset in the middle of a ping
    $display("[TB] async reset sequence");
    @(negedge wb_clk_i);
    #2;
    wb_rst_i = 1'b1;
    #1;
    checkOutput("async rst busy", 32'(busy), 32'h0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    checkReg("async rst THRESH0", 5'd16, 16'h0010);
    checkReg("async rst CONTROL", 5'd0, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
